ldl_rr_pri_v2: RTL and testbench

- Class-of-service round-robin arbiter with a registered output stage and starvation protection. It is the successor to the single-pointer priority arbiter.
- Supports a non-power-of-2 requester count and keeps an independent round-robin pointer per class, so traffic in one class does not disturb fairness in another.
- Low-class requesters that keep losing are aged and promoted to the top class.
- Sits between N request sources and one downstream consumer with a valid/ready handshake.

---
 rtl/ldl_rr_pri_v2.sv | 144 ++++++++++++++
 tb/tb_ldl_rr_pri_v2.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ldl_rr_pri_v2.sv
// Class-of-service round-robin arbiter with per-class pointers, age-based promotion
// of starving requesters, and a registered valid/ready output stage.
module ldl_rr_pri_v2 #(
    parameter int NUM_REQ    = 8,
    parameter int BIN_WIDTH  = $clog2(NUM_REQ),
    parameter int COS_WIDTH  = 2,
    parameter int USER_WIDTH = 1,
    parameter int AGE_WIDTH  = 4,
    parameter int AGE_LIMIT  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*COS_WIDTH-1:0]     icos,
    input  logic [NUM_REQ*USER_WIDTH-1:0]    iuser,
    input  logic                             ready,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             valid,
    output logic [BIN_WIDTH-1:0]             bin,
    output logic [COS_WIDTH-1:0]             ocos,
    output logic [USER_WIDTH-1:0]            ouser,
    output logic                             oaged
);

    localparam int NUM_CLS = 1 << COS_WIDTH;
    localparam logic [BIN_WIDTH-1:0] LAST_IDX = BIN_WIDTH'(NUM_REQ - 1);
    localparam bit AGING_EN = (AGE_LIMIT != 0);
    localparam logic [AGE_WIDTH-1:0] AGE_THR = AGING_EN ? AGE_WIDTH'(AGE_LIMIT) : '1;

    logic [BIN_WIDTH-1:0] ptr_q [NUM_CLS];
    logic [AGE_WIDTH-1:0] age_q [NUM_REQ];
    logic [COS_WIDTH-1:0] ecos  [NUM_REQ];

    logic                  load;
    logic                  grant;
    logic                  found;
    logic [COS_WIDTH-1:0]  top;
    logic [BIN_WIDTH-1:0]  base;
    logic [NUM_REQ-1:0]    cand;
    logic [NUM_REQ-1:0]    cand_hi;
    logic [NUM_REQ-1:0]    win_oh;
    logic [BIN_WIDTH-1:0]  win;
    logic [BIN_WIDTH-1:0]  nxt_ptr;
    logic [COS_WIDTH-1:0]  sel_cos;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_aged;

    assign load = !valid || ready;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (AGING_EN && (age_q[i] >= AGE_THR)) begin
                ecos[i] = '1;
            end else begin
                ecos[i] = icos[i*COS_WIDTH +: COS_WIDTH];
            end
        end
    end

    // Rotate-by-mask scan: candidates at or above the pointer first, then wrap to the
    // lowest candidate. An out-of-range pointer empties cand_hi and so wraps cleanly.
    always_comb begin
        top     = '0;
        cand    = '0;
        cand_hi = '0;
        win     = '0;
        win_oh  = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (ecos[i] > top)) begin
                top = ecos[i];
            end
        end
        base = ptr_q[top];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand[i]    = req[i] && (ecos[i] == top);
            cand_hi[i] = cand[i] && (BIN_WIDTH'(i) >= base);
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (cand_hi[i] && !found) begin
                win       = BIN_WIDTH'(i);
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (cand[i] && !found) begin
                win       = BIN_WIDTH'(i);
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        sel_cos  = '0;
        sel_user = '0;
        sel_aged = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_cos  = icos[i*COS_WIDTH +: COS_WIDTH];
                sel_user = iuser[i*USER_WIDTH +: USER_WIDTH];
                sel_aged = (ecos[i] != icos[i*COS_WIDTH +: COS_WIDTH]);
            end
        end
    end

    assign grant   = load && found;
    assign ack     = grant ? win_oh : '0;
    assign nxt_ptr = (win == LAST_IDX) ? '0 : win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            bin   <= '0;
            ocos  <= '0;
            ouser <= '0;
            oaged <= 1'b0;
            for (int unsigned c = 0; c < NUM_CLS; c++) begin
                ptr_q[c] <= '0;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= '0;
            end
        end else if (load) begin
            valid <= grant;
            if (grant) begin
                bin        <= win;
                ocos       <= sel_cos;
                ouser      <= sel_user;
                oaged      <= sel_aged;
                ptr_q[top] <= nxt_ptr;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (win_oh[i] || !req[i]) begin
                        age_q[i] <= '0;
                    end else if (age_q[i] != '1) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ldl_rr_pri_v2.sv
// Scoreboard bench for ldl_rr_pri_v2: an 8-requester instance without aging and a
// 5-requester instance with AGE_LIMIT=3, both driven with directed vectors.
module tb_ldl_rr_pri_v2;

    typedef struct packed {
        logic [2:0] b;
        logic [1:0] c;
        logic       u;
        logic       a;
    } exp_t;

    logic clk;
    logic rst;

    logic [7:0]  req_a, ack_a, iuser_a;
    logic [15:0] icos_a;
    logic        ready_a, valid_a, ouser_a, oaged_a;
    logic [2:0]  bin_a;
    logic [1:0]  ocos_a;

    logic [4:0]  req_b, ack_b, iuser_b;
    logic [9:0]  icos_b;
    logic        ready_b, valid_b, ouser_b, oaged_b;
    logic [2:0]  bin_b;
    logic [1:0]  ocos_b;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea_m, eb_m, dummy;
    int   checks = 0;
    int   errors = 0;

    ldl_rr_pri_v2 #(.NUM_REQ(8), .COS_WIDTH(2), .USER_WIDTH(1), .AGE_WIDTH(4), .AGE_LIMIT(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .icos(icos_a), .iuser(iuser_a), .ready(ready_a),
        .ack(ack_a), .valid(valid_a), .bin(bin_a), .ocos(ocos_a), .ouser(ouser_a), .oaged(oaged_a)
    );

    ldl_rr_pri_v2 #(.NUM_REQ(5), .COS_WIDTH(2), .USER_WIDTH(1), .AGE_WIDTH(4), .AGE_LIMIT(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .icos(icos_b), .iuser(iuser_b), .ready(ready_b),
        .ack(ack_b), .valid(valid_b), .bin(bin_b), .ocos(ocos_b), .ouser(ouser_b), .oaged(oaged_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: compare each accepted output-stage transaction against the scoreboard.
    always @(negedge clk) begin
        if (!rst && valid_a && ready_a) begin
            if (qa.size() == 0) begin
                chk("a_spurious_grant", 32'(qa.size()), 32'd1);
            end else begin
                ea_m = qa.pop_front();
                chk("a_bin", 32'(bin_a), 32'(ea_m.b));
                chk("a_ocos", 32'(ocos_a), 32'(ea_m.c));
                chk("a_ouser", 32'(ouser_a), 32'(ea_m.u));
                chk("a_oaged", 32'(oaged_a), 32'(ea_m.a));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b && ready_b) begin
            if (qb.size() == 0) begin
                chk("b_spurious_grant", 32'(qb.size()), 32'd1);
            end else begin
                eb_m = qb.pop_front();
                chk("b_bin", 32'(bin_b), 32'(eb_m.b));
                chk("b_ocos", 32'(ocos_b), 32'(eb_m.c));
                chk("b_ouser", 32'(ouser_b), 32'(eb_m.u));
                chk("b_oaged", 32'(oaged_b), 32'(eb_m.a));
            end
        end
    end

    task automatic a_cyc(input logic [7:0] eack, input logic [2:0] eb, input logic [1:0] ec,
                         input logic eu, input logic ea);
        if (eack != 8'h00) qa.push_back('{b: eb, c: ec, u: eu, a: ea});
        @(negedge clk);
        chk("a_ack", 32'(ack_a), 32'(eack));
        @(posedge clk);
        #1;
    endtask

    task automatic b_cyc(input logic [4:0] eack, input logic [2:0] eb, input logic [1:0] ec,
                         input logic eu, input logic ea);
        if (eack != 5'h00) qb.push_back('{b: eb, c: ec, u: eu, a: ea});
        @(negedge clk);
        chk("b_ack", 32'(ack_b), 32'(eack));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_a = '0; icos_a = '0; iuser_a = 8'b1010_0110; ready_a = 1'b1;
        req_b = '0; icos_b = '0; iuser_b = 5'b10110;     ready_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_bin_a", 32'(bin_a), 32'd0);
        chk("rst_ocos_a", 32'(ocos_a), 32'd0);
        chk("rst_ouser_a", 32'(ouser_a), 32'd0);
        chk("rst_oaged_a", 32'(oaged_a), 32'd0);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_valid", 32'(valid_a), 32'd0);
            chk("idle_ack", 32'(ack_a), 32'd0);
            chk("idle_bin", 32'(bin_a), 32'd0);
        end
        @(posedge clk);
        #1;

        // Same-class round robin: 0..7 then wrap to 0
        icos_a = 16'h5555;
        req_a  = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            a_cyc(8'(1 << (k % 8)), 3'(k % 8), 2'd1, iuser_a[k % 8], 1'b0);
        end

        // Class 3 (req 2,5) beats class 0 (req 0)
        icos_a = 16'h0C30;
        req_a  = 8'h25;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) a_cyc(8'h04, 3'd2, 2'd3, 1'b1, 1'b0);
            else            a_cyc(8'h20, 3'd5, 2'd3, 1'b1, 1'b0);
        end
        req_a = 8'h01;
        a_cyc(8'h01, 3'd0, 2'd0, 1'b0, 1'b0);
        req_a = 8'h25;
        a_cyc(8'h04, 3'd2, 2'd3, 1'b1, 1'b0);
        a_cyc(8'h20, 3'd5, 2'd3, 1'b1, 1'b0);

        // Backpressure: grant for req 5 held while inputs churn
        ready_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_a  = 8'(k * 37 + 3);
            icos_a = 16'(k * 4969);
            @(negedge clk);
            chk("bp_ack", 32'(ack_a), 32'd0);
            chk("bp_valid", 32'(valid_a), 32'd1);
            chk("bp_bin", 32'(bin_a), 32'd5);
            chk("bp_ocos", 32'(ocos_a), 32'd3);
            chk("bp_ouser", 32'(ouser_a), 32'd1);
            @(posedge clk);
            #1;
        end
        ready_a = 1'b1;
        req_a   = 8'h25;
        icos_a  = 16'h0C30;
        a_cyc(8'h04, 3'd2, 2'd3, 1'b1, 1'b0);
        req_a = 8'h00;
        a_cyc(8'h00, 3'd0, 2'd0, 1'b0, 1'b0);
        a_cyc(8'h00, 3'd0, 2'd0, 1'b0, 1'b0);

        // Aging: req 1 (class 0) promoted after three losses to req 4 (class 2)
        req_b  = 5'b10010;
        icos_b = 10'h200;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) b_cyc(5'h10, 3'd4, 2'd2, 1'b1, 1'b0);
            b_cyc(5'h02, 3'd1, 2'd0, 1'b1, 1'b1);
        end

        // Non-power-of-2 wrap, then asynchronous reset mid-sequence
        req_b  = 5'b10001;
        icos_b = 10'h155;
        b_cyc(5'h01, 3'd0, 2'd1, 1'b0, 1'b0);
        b_cyc(5'h10, 3'd4, 2'd1, 1'b1, 1'b0);
        b_cyc(5'h01, 3'd0, 2'd1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_valid_b", 32'(valid_b), 32'd0);
        chk("arst_bin_b", 32'(bin_b), 32'd0);
        dummy = qb.pop_back();
        #2 rst = 1'b0;
        b_cyc(5'h01, 3'd0, 2'd1, 1'b0, 1'b0);
        b_cyc(5'h10, 3'd4, 2'd1, 1'b1, 1'b0);
        req_b = 5'b00000;
        b_cyc(5'h00, 3'd0, 2'd0, 1'b0, 1'b0);
        b_cyc(5'h00, 3'd0, 2'd0, 1'b0, 1'b0);

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
